// File: rtl/csr_load_sched_if.sv
// csr_load_sched_if: packer input stream plus the 32-bit matrix memory
// write port. The slave modport is the scheduler's view; the master modport
// is the environment (packer and memory) view.
interface csr_load_sched_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [63:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_data, in_last, mem_ready,
    input  in_ready, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last, mem_ready,
    output in_ready, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/csr_load_sched.sv
// csr_load_sched: parses a CSR matrix stream (header, entry words, row
// pointer words) from a small FIFO and issues 32-bit write beats into the
// value, column-index and row-pointer regions.
// Optional build macro CSR_SCHED_CHECK_EN enables in_last/nrows protocol
// checking and the sticky ERR state; without it sequencing is count-driven.
module csr_load_sched #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VAL_BASE   = 'h0000,
  parameter logic [ADDR_W-1:0] COL_BASE   = 'h4000,
  parameter logic [ADDR_W-1:0] ROW_BASE   = 'h8000
) (
  input  logic                  clk,
  input  logic                  reset,
  csr_load_sched_if.slave       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, HDR, ENTRY_V, ENTRY_C, ROWPTR
`ifdef CSR_SCHED_CHECK_EN
    , ERR
`endif
  } state_t;

  state_t state;

  // ---------------- input FIFO ----------------
  logic [63:0]           fdata [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] flast;
  logic [PW-1:0]         rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]         count;
  logic                  push, pop, not_empty, have_nxt;
  logic [63:0]           head, nxt;
  logic                  head_last;

  assign not_empty = (count != '0);
  assign have_nxt  = (count > CW'(1));
  assign rd_nxt    = rd_ptr + PW'(1);
  assign head      = fdata[rd_ptr];
  assign head_last = flast[rd_ptr];
  assign nxt       = fdata[rd_nxt];

`ifdef CSR_SCHED_CHECK_EN
  // After an error the input is swallowed so the packer never stalls.
  assign bus.in_ready = (count != CW'(FIFO_DEPTH)) || (state == ERR);
  assign push         = bus.in_valid && bus.in_ready && (state != ERR);
`else
  assign bus.in_ready = (count != CW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
`endif

  // ---------------- write port registers ----------------
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              beat_done;

  assign bus.mem_wen   = wen;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign beat_done     = wen && bus.mem_ready;

  logic [31:0] e, r, nnz, nrows, e_inc, r_inc;
  logic        e_last, r_last;

  assign e_inc  = e + 32'd1;
  assign r_inc  = r + 32'd1;
  assign e_last = (e_inc == nnz);
  assign r_last = (r == nrows);

  // Pop the head on header parse, on each completed C beat and row pointer
  // beat, and unconditionally while flushing in ERR.
  always_comb begin
    pop = 1'b0;
    case (state)
      HDR:     pop = not_empty;
      ENTRY_C: pop = beat_done;
      ROWPTR:  pop = beat_done;
`ifdef CSR_SCHED_CHECK_EN
      ERR:     pop = not_empty;
`endif
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fdata[wr_ptr] <= bus.in_data;
      flast[wr_ptr] <= bus.in_last;
    end
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

`ifdef CSR_SCHED_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = head_last;
  assign err = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Main sequencer. On each completed beat the next beat is loaded in the
  // same edge (from the FIFO's second slot when the head is popped) so a
  // steady stream writes one beat per cycle. A pending beat is never
  // changed until it completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      e     <= '0;
      r     <= '0;
      nnz   <= '0;
      nrows <= '0;
      wen   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      done  <= 1'b0;
`ifdef CSR_SCHED_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (not_empty) state <= HDR;

        HDR: begin
          nnz   <= head[63:32];
          nrows <= head[31:0];
          e     <= '0;
          r     <= '0;
          state <= (head[63:32] == 32'd0) ? ROWPTR : ENTRY_V;
`ifdef CSR_SCHED_CHECK_EN
          if (head_last || (head[31:0] == 32'hFFFF_FFFF)) begin
            state <= ERR;
            err_q <= 1'b1;
          end
`endif
        end

        ENTRY_V: begin
          if (beat_done) begin
            state <= ENTRY_C;
            addr  <= COL_BASE + e[ADDR_W-1:0];
            wdata <= head[31:0];
          end else if (!wen && not_empty) begin
            wen   <= 1'b1;
            addr  <= VAL_BASE + e[ADDR_W-1:0];
            wdata <= head[63:32];
          end
        end

        ENTRY_C: begin
          if (beat_done) begin
            e   <= e_inc;
            wen <= have_nxt;
            if (e_last) begin
              state <= ROWPTR;
              if (have_nxt) begin
                addr  <= ROW_BASE + r[ADDR_W-1:0];
                wdata <= nxt[31:0];
              end
            end else begin
              state <= ENTRY_V;
              if (have_nxt) begin
                addr  <= VAL_BASE + e_inc[ADDR_W-1:0];
                wdata <= nxt[63:32];
              end
            end
`ifdef CSR_SCHED_CHECK_EN
            if (head_last) begin
              state <= ERR;
              err_q <= 1'b1;
              wen   <= 1'b0;
            end
`endif
          end
        end

        ROWPTR: begin
          if (beat_done) begin
            r <= r_inc;
            if (r_last) begin
              state <= IDLE;
              wen   <= 1'b0;
              done  <= 1'b1;
`ifdef CSR_SCHED_CHECK_EN
              if (!head_last) begin
                state <= ERR;
                err_q <= 1'b1;
                done  <= 1'b0;
              end
`endif
            end else begin
              wen <= have_nxt;
              if (have_nxt) begin
                addr  <= ROW_BASE + r_inc[ADDR_W-1:0];
                wdata <= nxt[31:0];
              end
`ifdef CSR_SCHED_CHECK_EN
              if (head_last) begin
                state <= ERR;
                err_q <= 1'b1;
                wen   <= 1'b0;
              end
`endif
            end
          end else if (!wen && not_empty) begin
            wen   <= 1'b1;
            addr  <= ROW_BASE + r[ADDR_W-1:0];
            wdata <= head[31:0];
          end
        end

`ifdef CSR_SCHED_CHECK_EN
        ERR: wen <= 1'b0;
`endif

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_load_sched.sv
// tb_csr_load_sched: directed stimulus for csr_load_sched with hand-computed
// write sequences, checked by immediate assertions.
module tb_csr_load_sched;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, done, err;

  always #5 clk = ~clk;

  csr_load_sched_if #(.ADDR_W(ADDR_W)) bus ();

  csr_load_sched #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] wq[$];
  bit          lq[$];
  int          widx;
  bit          push_en;
  bit          hold_ready;
  logic [15:0] stall_addr;
  int          stall_left;
  int          stall_seen;
  bit          stall_chk;
  int          acc_cnt;
  int          done_cnt;
  logic        busy_at_done;
  logic [47:0] log_q[$];
  logic [47:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] hi, input logic [31:0] lo, input bit last);
    wq.push_back({hi, lo});
    lq.push_back(last);
  endtask

  task automatic ex(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic new_stream();
    wq.delete();
    lq.delete();
    log_q.delete();
    exp_q.delete();
    widx     = 0;
    acc_cnt  = 0;
    done_cnt = 0;
  endtask

  // One clock: drive just after the rising edge, sample at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.in_valid  = push_en && (widx < wq.size());
    bus.in_data   = (widx < wq.size()) ? wq[widx] : 64'd0;
    bus.in_last   = (widx < lq.size()) ? lq[widx] : 1'b0;
    bus.mem_ready = !hold_ready &&
                    !(bus.mem_wen && bus.mem_addr == stall_addr && stall_left > 0);
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      widx++;
      acc_cnt++;
    end
    if (bus.mem_wen && bus.mem_addr == stall_addr) begin
      stall_seen++;
      if (stall_chk) chk("col0_stable", {16'd0, bus.mem_addr, bus.mem_wdata}, {16'd0, 16'h4000, 32'd0});
      if (!bus.mem_ready && stall_left > 0) stall_left--;
    end
    if (bus.mem_wen && bus.mem_ready) log_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_done(input string tag, input int max);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max) begin
      cyc();
      n++;
    end
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nbeats"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size())
        chk($sformatf("%s_beat%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic t1_stream();
    add(32'd2, 32'd1, 1'b0);
    add(32'd5, 32'd0, 1'b0);
    add(32'd7, 32'd1, 1'b0);
    add(32'd0, 32'd0, 1'b0);
    add(32'd0, 32'd2, 1'b1);
    ex(16'h0000, 32'd5); ex(16'h4000, 32'd0);
    ex(16'h0001, 32'd7); ex(16'h4001, 32'd1);
    ex(16'h8000, 32'd0); ex(16'h8001, 32'd2);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.in_last   = 1'b0;
    bus.mem_ready = 1'b1;
    push_en       = 1'b1;
    hold_ready    = 1'b0;
    stall_addr    = 16'hFFFF;
    stall_left    = 0;
    stall_seen    = 0;
    stall_chk     = 1'b0;
    busy_at_done  = 1'b1;
    widx = 0; acc_cnt = 0; done_cnt = 0;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mem_wen", 64'(bus.mem_wen), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Basic matrix, memory always ready
    new_stream();
    t1_stream();
    run_done("t1", 100);
    check_log("t1");
    cyc();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // Same stream, COL[0] stalled three cycles
    new_stream();
    t1_stream();
    stall_addr = 16'h4000; stall_left = 3; stall_seen = 0; stall_chk = 1'b1;
    run_done("t2", 100);
    check_log("t2");
    chk("t2_stall_cycles", 64'(stall_seen), 64'd4);
    stall_addr = 16'hFFFF; stall_left = 0; stall_chk = 1'b0;

    // Back-pressure: header first, then six words against a stalled port
    new_stream();
    hold_ready = 1'b1;
    add(32'd5, 32'd0, 1'b0);
    run(6);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) add(32'd10 + 32'(i), 32'(i), 1'b0);
    add(32'd0, 32'd5, 1'b1);
    run(10);
    chk("t3_accepts_full", 64'(acc_cnt), 64'd4);
    chk("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("t3_wen_held", 64'(bus.mem_wen), 64'd1);
    chk("t3_addr_held", 64'(bus.mem_addr), 64'h0000);
    hold_ready = 1'b0;
    run_done("t3", 200);
    chk("t3_accepts_all", 64'(acc_cnt), 64'd6);
    for (int i = 0; i < 5; i++) begin
      ex(16'(i), 32'd10 + 32'(i));
      ex(16'h4000 + 16'(i), 32'(i));
    end
    ex(16'h8000, 32'd5);
    check_log("t3");

    // Empty matrix: only ROW[0]
    new_stream();
    add(32'd0, 32'd0, 1'b0);
    add(32'd0, 32'd0, 1'b1);
    ex(16'h8000, 32'd0);
    run_done("t4", 100);
    check_log("t4");

    // Early in_last on the second of three entries
    new_stream();
    add(32'd3, 32'd0, 1'b0);
    add(32'd1, 32'd0, 1'b0);
    add(32'd2, 32'd1, 1'b1);
    run(20);
    ex(16'h0000, 32'd1); ex(16'h4000, 32'd0);
    ex(16'h0001, 32'd2); ex(16'h4001, 32'd1);
    check_log("t5a");
    chk("t5_wen_idle", 64'(bus.mem_wen), 64'd0);
    chk("t5_busy", 64'(busy), 64'd1);
    add(32'd4, 32'd2, 1'b0);
    run(10);
`ifdef CSR_SCHED_CHECK_EN
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_in_ready_forced", 64'(bus.in_ready), 64'd1);
`else
    chk("t5_err", 64'(err), 64'd0);
    ex(16'h0002, 32'd4); ex(16'h4002, 32'd2);
`endif
    check_log("t5b");

    // Reset during ENTRY_C, then a fresh matrix
    @(posedge clk); #1 reset = 1'b0;
    bus.in_valid = 1'b0;
    #1 reset = 1'b1;
    new_stream();
    add(32'd2, 32'd0, 1'b0);
    add(32'd1, 32'd0, 1'b0);
    stall_addr = 16'h4000; stall_left = 1000;
    run(10);
    chk("t6_in_col", 64'({bus.mem_wen, bus.mem_addr}), 64'({1'b1, 16'h4000}));
    @(posedge clk); #1 reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("t6_rst_wen", 64'(bus.mem_wen), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_rst_err", 64'(err), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    stall_addr = 16'hFFFF; stall_left = 0;
    new_stream();
    add(32'd1, 32'd0, 1'b0);
    add(32'd9, 32'd3, 1'b0);
    add(32'd0, 32'd1, 1'b1);
    ex(16'h0000, 32'd9); ex(16'h4000, 32'd3); ex(16'h8000, 32'd1);
    run_done("t6", 100);
    check_log("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
